stack_spill_fill_arbiter: RTL and testbench
===========================================

STACK_SPILL_FILL_ARBITER -- requirements
Module: stack_spill_fill_arbiter

Interface
REQ-001 SHALL use these parameters:
- DATA_W, 16, data width
- ADDR_W, 16, address width
- ID_W, 4, stack transaction ID width
- MAX_READS, 4, maximum fill reads in flight; tag width is log2(MAX_READS)

REQ-002 SHALL have these ports:
- clk  in  1  single clock; all state changes on its rising edge
- sync_rst  in  1  synchronous, active-low reset
- clk_en  in  1  global advance enable
- rd_valid  in  1  read-queue head valid
- rd_addr  in  ADDR_W  fill address
- rd_id  in  ID_W  stack ID
- rd_pop  out  1  read-queue head consumed
- wr_valid  in  1  write-queue head valid
- wr_addr  in  ADDR_W  spill address
- wr_data  in  DATA_W  spill value
- wr_id  in  ID_W  stack ID
- wr_pop  out  1  write-queue head consumed
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = spill, 0 = fill
- mem_req_addr  out  ADDR_W  request address
- mem_req_data  out  DATA_W  spill data (0 for fills)
- mem_req_tag  out  log2(MAX_READS)  fill tag (0 for spills)
- mem_resp_valid  in  1  fill response valid
- mem_resp_tag  in  log2(MAX_READS)  response tag
- mem_resp_data  in  DATA_W  response data
- fill_done_valid  out  1  fill complete, 1-cycle pulse
- fill_done_id  out  ID_W  ID of the completed fill
- fill_done_data  out  DATA_W  fill data
- spill_done_valid  out  1  spill accepted by memory, 1-cycle pulse
- spill_done_id  out  ID_W  ID of the accepted spill
- err_stray_resp  out  1  sticky: response received on an unallocated tag

Function
REQ-003 SHALL hold a single registered request stage; it is "free" when empty, or when mem_req_valid && mem_req_ready in the current cycle.
REQ-004 SHALL grant at most one queue per cycle, and only when the stage is free and clk_en=1.
- A read is eligible only if rd_valid=1, a tag is free and inflight < MAX_READS.
- A write is eligible if wr_valid=1.
REQ-005 SHALL arbitrate round-robin when both are eligible: the side not granted last wins; after reset, write wins first.
REQ-006 SHALL assert rd_pop or wr_pop combinationally in the grant cycle; the granted head appears on mem_req_* the next cycle (1-cycle latency).
REQ-007 SHALL hold mem_req_* stable while mem_req_valid=1 and mem_req_ready=0.
REQ-008 SHALL allocate the lowest-numbered free tag at read grant, recording {rd_id} in a MAX_READS-entry tag table; inflight increments.
REQ-009 SHALL pulse spill_done_valid with wr_id in the cycle after the spill handshake (mem_req_valid && mem_req_ready && mem_req_write).
REQ-010 SHALL, on mem_resp_valid with an allocated tag, the next cycle:
- pulse fill_done_valid with the table ID and registered mem_resp_data;
- free the tag and decrement inflight.
REQ-011 SHALL allow allocate and free of different tags in the same cycle, leaving inflight unchanged; a tag freed this cycle is not reallocatable until the next cycle.
REQ-012 SHALL, on mem_resp_valid with an unallocated tag, set err_stray_resp, emit no fill_done, and leave state unchanged.
REQ-013 SHALL, when clk_en=0, freeze all state and force rd_pop=wr_pop=0; the registered request stage holds.
REQ-014 SHALL keep inflight within 0..MAX_READS with no wrap, ensured by the eligibility rule.

Reset
REQ-015 SHALL, when sync_rst=0 at a clock edge:
- clear the request stage, all tags, inflight and err_stray_resp;
- set the round-robin pointer to write-first;
- drive all outputs to 0 the next cycle.
REQ-016 SHALL discard any in-flight fills on reset mid-operation; later responses for those tags raise err_stray_resp.
REQ-017 SHALL give reset priority over clk_en.

Structure
REQ-018 SHALL place DATA_W, ADDR_W, ID_W, MAX_READS and a stack memory-request struct {write, addr, data, tag} in the shared stack-cache package.
REQ-019 SHALL implement the tag table and free-vector as a sub-module, stack_fill_tag_table (allocate lowest free / lookup / free / valid-check).

Verification
REQ-020 SHALL cover these directed scenarios:
- Single fill: rd_valid, addr 0x0100, id 3, mem_req_ready=1 -> rd_pop in cycle 0, mem_req at cycle 1 with tag 0; response tag 0, data 0xBEEF -> fill_done id 3, data 0xBEEF one cycle later.
- Contention: both heads valid continuously, ready=1 -> grants alternate W,R,W,R starting with write; spill_done ids match wr_id.
- Fill limit: 5 fills, no responses -> 4 requests issued with tags 0-3, 5th held with rd_pop=0; response tag 2 -> 5th issues with tag 2.
- Backpressure: mem_req_ready=0 for 3 cycles -> mem_req_* stable, no pops, then drains on ready.
- Stray response: response tag 1 with no fills outstanding -> err_stray_resp=1 sticky, no fill_done.
- Reset mid-flight: 2 fills outstanding, sync_rst=0 -> all outputs 0, inflight 0; a late response sets err_stray_resp.

Source files
------------

// File: rtl/stack_cache_pkg.sv
// Shared stack-cache definitions: widths, derived tag sizes and the
// registered memory-request record used by the spill/fill arbiter.
package stack_cache_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int ID_W      = 4;
    localparam int MAX_READS = 4;

    // Fill tag width and a counter wide enough to hold 0..MAX_READS.
    localparam int TAG_W = $clog2(MAX_READS);
    localparam int CNT_W = $clog2(MAX_READS + 1);

    // One memory request as held in the request stage.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } stack_req_t;

endpackage

// File: rtl/stack_fill_tag_table.sv
// Outstanding-fill tag table: allocates the lowest free tag, remembers the
// stack ID per tag, answers lookups for responses and frees on completion.
module stack_fill_tag_table
    import stack_cache_pkg::*;
(
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             en,
    input  logic             alloc,
    input  logic [ID_W-1:0]  alloc_id,
    output logic             can_alloc,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic [ID_W-1:0]  lookup_id,
    input  logic             free
);

    logic [MAX_READS-1:0] valid_q;
    logic [ID_W-1:0]      id_q [MAX_READS];
    logic [CNT_W-1:0]     inflight_q;
    logic [MAX_READS-1:0] alloc_mask;
    logic [MAX_READS-1:0] free_mask;

    // Pick the lowest free tag from registered state only, so a tag freed
    // this cycle cannot be handed out again until the next cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        alloc_tag  = '0;
        alloc_mask = '0;
        free_mask  = '0;
        for (int i = MAX_READS - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_tag = TAG_W'(i);
        end
        can_alloc = (valid_q != '1) && (inflight_q < CNT_W'(MAX_READS));
        if (alloc) alloc_mask[alloc_tag] = 1'b1;
        if (free)  free_mask[lookup_tag] = 1'b1;
    end

    assign lookup_hit = valid_q[lookup_tag];
    assign lookup_id  = id_q[lookup_tag];

    // Tag ownership and the in-flight count; alloc and free of different
    // tags in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!sync_rst) begin
            valid_q    <= '0;
            inflight_q <= '0;
        end else if (en) begin
            valid_q    <= (valid_q | alloc_mask) & ~free_mask;
            inflight_q <= inflight_q + CNT_W'(alloc) - CNT_W'(free);
        end
    end

    // Stack ID per tag, written at allocation.
    always_ff @(posedge clk) begin
        // NOTE: the ID array is not reset; valid_q alone says which entries mean anything.
        if (en && alloc) id_q[alloc_tag] <= alloc_id;
    end

endmodule

// File: rtl/stack_spill_fill_arbiter.sv
// Stack spill/fill arbiter: round-robin between the fill (read) and spill
// (write) queues into one registered memory-request stage, with tagged fill
// tracking, completion pulses and a sticky stray-response flag.
module stack_spill_fill_arbiter #(
    parameter int  DATA_W    = stack_cache_pkg::DATA_W,
    parameter int  ADDR_W    = stack_cache_pkg::ADDR_W,
    parameter int  ID_W      = stack_cache_pkg::ID_W,
    parameter int  MAX_READS = stack_cache_pkg::MAX_READS,
    localparam int TAG_W     = $clog2(MAX_READS)
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              clk_en,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ID_W-1:0]   rd_id,
    output logic              rd_pop,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ID_W-1:0]   wr_id,
    output logic              wr_pop,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic [TAG_W-1:0]  mem_req_tag,
    input  logic              mem_resp_valid,
    input  logic [TAG_W-1:0]  mem_resp_tag,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              fill_done_valid,
    output logic [ID_W-1:0]   fill_done_id,
    output logic [DATA_W-1:0] fill_done_data,
    output logic              spill_done_valid,
    output logic [ID_W-1:0]   spill_done_id,
    output logic              err_stray_resp
);
    import stack_cache_pkg::*;

    stack_req_t       stage_q;
    logic             stage_valid_q;
    logic [ID_W-1:0]  stage_id_q;
    logic             last_write_q;   // 1 when the most recent grant went to the write queue

    logic             can_alloc;
    logic [TAG_W-1:0] alloc_tag;
    logic             lookup_hit;
    logic [ID_W-1:0]  lookup_id;
    logic             handshake;
    logic             grant_ok;
    logic             grant_rd;
    logic             grant_wr;
    logic             resp_hit;
    logic             resp_stray;

    assign handshake  = stage_valid_q && mem_req_ready;
    assign grant_ok   = sync_rst && clk_en && (!stage_valid_q || mem_req_ready);
    assign resp_hit   = mem_resp_valid && lookup_hit;
    assign resp_stray = mem_resp_valid && !lookup_hit;

    stack_fill_tag_table u_tags (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .en         (clk_en),
        .alloc      (grant_rd),
        .alloc_id   (rd_id),
        .can_alloc  (can_alloc),
        .alloc_tag  (alloc_tag),
        .lookup_tag (mem_resp_tag),
        .lookup_hit (lookup_hit),
        .lookup_id  (lookup_id),
        .free       (resp_hit && clk_en)
    );

    // Round-robin grant: under contention the side not granted last wins.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (grant_ok) begin
            if (wr_valid && rd_valid && can_alloc) begin
                grant_wr = !last_write_q;
                grant_rd = last_write_q;
            end else begin
                grant_wr = wr_valid;
                grant_rd = rd_valid && can_alloc;
            end
        end
    end

    assign rd_pop = grant_rd;
    assign wr_pop = grant_wr;

    assign mem_req_valid = stage_valid_q;
    assign mem_req_write = stage_q.write;
    assign mem_req_addr  = stage_q.addr;
    assign mem_req_data  = stage_q.data;
    assign mem_req_tag   = stage_q.tag;

    // Request stage: load the granted head, hold under backpressure, empty on handshake.
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            stage_id_q    <= '0;
            last_write_q  <= 1'b0;
        end else if (clk_en) begin
            if (grant_wr) begin
                stage_valid_q <= 1'b1;
                stage_q       <= '{write: 1'b1, addr: wr_addr, data: wr_data, tag: '0};
                stage_id_q    <= wr_id;
                last_write_q  <= 1'b1;
            end else if (grant_rd) begin
                stage_valid_q <= 1'b1;
                stage_q       <= '{write: 1'b0, addr: rd_addr, data: '0, tag: alloc_tag};
                stage_id_q    <= rd_id;
                last_write_q  <= 1'b0;
            end else if (handshake) begin
                stage_valid_q <= 1'b0;
            end
        end
    end

    // Completion pulses and the sticky stray-response flag.
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            spill_done_valid <= 1'b0;
            spill_done_id    <= '0;
            fill_done_valid  <= 1'b0;
            fill_done_id     <= '0;
            fill_done_data   <= '0;
            err_stray_resp   <= 1'b0;
        end else begin
            spill_done_valid <= clk_en && handshake && stage_q.write;
            fill_done_valid  <= clk_en && resp_hit;
            if (clk_en && handshake && stage_q.write) spill_done_id <= stage_id_q;
            if (clk_en && resp_hit) begin
                fill_done_id   <= lookup_id;
                fill_done_data <= mem_resp_data;
            end
            if (clk_en && resp_stray) err_stray_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stack_spill_fill_arbiter.sv
// Self-checking bench for stack_spill_fill_arbiter: directed scenarios then
// randomized traffic, all checked against a transaction-level model.
module tb_stack_spill_fill_arbiter;

    logic        clk = 1'b0;
    logic        sync_rst, clk_en;
    logic        rd_valid, wr_valid, rd_pop, wr_pop;
    logic [15:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  rd_id, wr_id;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [15:0] mem_req_addr, mem_req_data;
    logic [1:0]  mem_req_tag;
    logic        mem_resp_valid;
    logic [1:0]  mem_resp_tag;
    logic [15:0] mem_resp_data;
    logic        fill_done_valid, spill_done_valid, err_stray_resp;
    logic [3:0]  fill_done_id, spill_done_id;
    logic [15:0] fill_done_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending request, set of owned tags, fairness memory, expected pulses.
    bit          m_valid, m_write;
    logic [15:0] m_addr, m_data;
    logic [1:0]  m_tag;
    logic [3:0]  m_id;
    bit          m_alloc [4];
    logic [3:0]  m_tid [4];
    bit          m_last_wr;
    bit          m_fill_v, m_spill_v, m_err;
    logic [3:0]  m_fill_id, m_spill_id;
    logic [15:0] m_fill_data;

    always #5 clk = ~clk;

    stack_spill_fill_arbiter dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_id(rd_id), .rd_pop(rd_pop),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_id(wr_id), .wr_pop(wr_pop),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
        .fill_done_valid(fill_done_valid), .fill_done_id(fill_done_id), .fill_done_data(fill_done_data),
        .spill_done_valid(spill_done_valid), .spill_done_id(spill_done_id),
        .err_stray_resp(err_stray_resp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_write = 0; m_addr = '0; m_data = '0; m_tag = '0; m_id = '0;
        for (int t = 0; t < 4; t++) begin m_alloc[t] = 0; m_tid[t] = '0; end
        m_last_wr = 0;
        m_fill_v = 0; m_spill_v = 0; m_err = 0;
        m_fill_id = '0; m_spill_id = '0; m_fill_data = '0;
    endtask

    task automatic idle_inputs();
        sync_rst = 1; clk_en = 1;
        rd_valid = 0; rd_addr = '0; rd_id = '0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_id = '0;
        mem_req_ready = 1; mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
    endtask

    // One clock: inputs are already driven (at the falling edge).
    task automatic cycle();
        bit   g_rd, g_wr, hs;
        int   low, busy;
        #1;
        g_rd = 0; g_wr = 0; low = -1; busy = 0;
        for (int t = 3; t >= 0; t--) if (!m_alloc[t]) low = t;
        for (int t = 0; t < 4; t++) if (m_alloc[t]) busy++;
        if (sync_rst && clk_en && (!m_valid || mem_req_ready)) begin
            if (wr_valid && rd_valid && busy < 4) begin
                g_wr = !m_last_wr;
                g_rd = m_last_wr;
            end else begin
                g_wr = wr_valid;
                g_rd = rd_valid && busy < 4;
            end
        end
        check("rd_pop", rd_pop, g_rd);
        check("wr_pop", wr_pop, g_wr);

        if (!sync_rst) begin
            model_reset();
        end else if (!clk_en) begin
            m_fill_v = 0; m_spill_v = 0;
        end else begin
            hs = m_valid && mem_req_ready;
            m_spill_v = hs && m_write;
            if (m_spill_v) m_spill_id = m_id;
            m_fill_v = 0;
            if (mem_resp_valid) begin
                if (m_alloc[mem_resp_tag]) begin
                    m_fill_v = 1; m_fill_id = m_tid[mem_resp_tag]; m_fill_data = mem_resp_data;
                    m_alloc[mem_resp_tag] = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (g_wr) begin
                m_valid = 1; m_write = 1; m_addr = wr_addr; m_data = wr_data; m_tag = '0; m_id = wr_id;
                m_last_wr = 1;
            end else if (g_rd) begin
                m_valid = 1; m_write = 0; m_addr = rd_addr; m_data = '0; m_tag = 2'(low); m_id = rd_id;
                m_alloc[low] = 1; m_tid[low] = rd_id;
                m_last_wr = 0;
            end else if (hs) begin
                m_valid = 0;
            end
        end

        @(negedge clk);
        check("req_valid", mem_req_valid, m_valid);
        if (m_valid) begin
            check("req_write", mem_req_write, m_write);
            check("req_addr", mem_req_addr, m_addr);
            check("req_data", mem_req_data, m_data);
            check("req_tag", mem_req_tag, m_tag);
        end
        check("fill_valid", fill_done_valid, m_fill_v);
        if (m_fill_v) begin
            check("fill_id", fill_done_id, m_fill_id);
            check("fill_data", fill_done_data, m_fill_data);
        end
        check("spill_valid", spill_done_valid, m_spill_v);
        if (m_spill_v) check("spill_id", spill_done_id, m_spill_id);
        check("err_stray", err_stray_resp, m_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_req_write"}, mem_req_write, 0);
        check({tag, "_req_addr"}, mem_req_addr, 0);
        check({tag, "_req_data"}, mem_req_data, 0);
        check({tag, "_req_tag"}, mem_req_tag, 0);
        check({tag, "_fill"}, {fill_done_valid, fill_done_id, fill_done_data}, 0);
        check({tag, "_spill"}, {spill_done_valid, spill_done_id}, 0);
        check({tag, "_err"}, err_stray_resp, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        sync_rst = 0;
        cycle();
        cycle();
        sync_rst = 1;
    endtask

    initial begin
        int k;
        model_reset();
        idle_inputs();
        @(negedge clk);

        // Reset state.
        do_reset();
        check_all_zero("reset");

        // Single fill: addr 0x0100, id 3 -> tag 0, response 0xBEEF.
        rd_valid = 1; rd_addr = 16'h0100; rd_id = 4'd3;
        cycle();
        rd_valid = 0;
        check("single_req_tag", mem_req_tag, 0);
        check("single_req_addr", mem_req_addr, 16'h0100);
        mem_resp_valid = 1; mem_resp_tag = 2'd0; mem_resp_data = 16'hBEEF;
        cycle();
        mem_resp_valid = 0;
        check("single_fill_id", fill_done_id, 4'd3);
        check("single_fill_data", fill_done_data, 16'hBEEF);
        cycle();

        // Contention: both heads valid, write first then alternating.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rd_valid = 1; rd_addr = 16'(16'h0200 + i); rd_id = 4'(i);
            wr_valid = 1; wr_addr = 16'(16'h0300 + i); wr_data = 16'(16'hA000 + i); wr_id = 4'(8 + i);
            if (i == 0) begin #1; check("contention_first_wr", wr_pop, 1); end
            cycle();
            wr_valid = 0; rd_valid = 0;
        end
        mem_resp_valid = 1;
        for (int t = 0; t < 3; t++) begin mem_resp_tag = 2'(t); cycle(); end
        mem_resp_valid = 0;
        cycle();

        // Fill limit: five fills, no responses; tag 2 returns, fifth issues on tag 2.
        do_reset();
        rd_valid = 1;
        for (int i = 0; i < 5; i++) begin rd_addr = 16'(16'h0400 + i); rd_id = 4'(i); cycle(); end
        check("limit_held", rd_pop, 0);
        mem_resp_valid = 1; mem_resp_tag = 2'd2; mem_resp_data = 16'h1234;
        cycle();
        mem_resp_valid = 0;
        cycle();
        rd_valid = 0;
        check("limit_reuse_tag", mem_req_tag, 2);
        cycle();

        // Backpressure: three cycles not ready, then drain.
        do_reset();
        wr_valid = 1; wr_addr = 16'h0500; wr_data = 16'h5555; wr_id = 4'd5;
        cycle();
        mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 16'(16'h0600 + i); cycle();
            check("bp_hold_addr", mem_req_addr, 16'h0500);
        end
        wr_valid = 0; mem_req_ready = 1;
        cycle();
        check("bp_spill_id", spill_done_id, 4'd5);
        cycle();

        // Stray response with nothing outstanding.
        do_reset();
        mem_resp_valid = 1; mem_resp_tag = 2'd1;
        cycle();
        mem_resp_valid = 0;
        check("stray_err", err_stray_resp, 1);
        check("stray_no_fill", fill_done_valid, 0);
        cycle(); cycle();
        check("stray_sticky", err_stray_resp, 1);

        // Reset mid-flight with two fills outstanding; late response is stray.
        do_reset();
        rd_valid = 1; rd_addr = 16'h0700; rd_id = 4'd7;
        cycle(); cycle();
        idle_inputs();
        sync_rst = 0;
        cycle();
        sync_rst = 1;
        check_all_zero("midrst");
        mem_resp_valid = 1; mem_resp_tag = 2'd0;
        cycle();
        mem_resp_valid = 0;
        check("midrst_late_err", err_stray_resp, 1);
        check("midrst_no_fill", fill_done_valid, 0);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            sync_rst       = ($urandom_range(0, 299) != 0);
            clk_en         = ($urandom_range(0, 9) != 0);
            rd_valid       = ($urandom_range(0, 9) < 6);
            rd_addr        = 16'($urandom);
            rd_id          = 4'($urandom);
            wr_valid       = ($urandom_range(0, 9) < 5);
            wr_addr        = 16'($urandom);
            wr_data        = 16'($urandom);
            wr_id          = 4'($urandom);
            mem_req_ready  = clk_en && ($urandom_range(0, 9) < 7);
            mem_resp_valid = 0;
            mem_resp_tag   = 2'($urandom);
            mem_resp_data  = 16'($urandom);
            if (clk_en) begin
                if ($urandom_range(0, 99) < 3) begin
                    mem_resp_valid = 1;
                end else if ($urandom_range(0, 9) < 4) begin
                    k = $urandom_range(0, 3);
                    for (int j = 0; j < 4; j++) begin
                        if (!mem_resp_valid && m_alloc[(k + j) % 4]) begin
                            mem_resp_valid = 1;
                            mem_resp_tag   = 2'((k + j) % 4);
                        end
                    end
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
